// File: rtl/fetch_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_issue_ctrl
//  Purpose  : Fetch/issue sequencer for a small in-order core. Interlocks
//             branches behind recent writers, holds issue while a branch
//             resolves, and detects single-instruction halt loops.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_issue_ctrl #(
    parameter int HAZ_GAP = 3,
    parameter int BR_LAT  = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RUN,
    output logic [5:0] AD,
    input  logic [9:0] Q,
    input  logic       BR_TAKEN,
    output logic [9:0] IR,
    output logic       IR_VALID,
    output logic       STALL,
    output logic       HALT
);

    localparam int c_GW = (HAZ_GAP > 0) ? $clog2(HAZ_GAP + 1) : 1;
    localparam int c_WW = (BR_LAT > 1) ? $clog2(BR_LAT) : 1;

    localparam logic [c_GW-1:0] c_GAP_MAX   = c_GW'(HAZ_GAP);
    localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'(BR_LAT - 1);

    localparam logic [3:0] c_OP_NOP = 4'b0000;
    localparam logic [3:0] c_OP_JMP = 4'b1011;
    localparam logic [3:0] c_OP_JNZ = 4'b1100;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_BR_WAIT = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    state_t          r_state, w_state_nx;
    logic [5:0]      r_pc, w_pc_nx;
    logic [c_GW-1:0] r_gap, w_gap_nx;
    logic [c_WW-1:0] r_wcnt, w_wcnt_nx;
    logic [3:0]      r_br_op, w_br_op_nx;
    logic [5:0]      r_br_tgt, w_br_tgt_nx;
    logic [9:0]      r_ir, w_ir_nx;
    logic            r_ir_valid, w_ir_valid_nx;
    logic            r_stall, w_stall_nx;
    logic            r_halt, w_halt_nx;

    logic [3:0]      w_op;
    logic            w_is_br;
    logic            w_taken;

    assign w_op    = Q[9:6];
    assign w_is_br = (w_op == c_OP_JMP) || (w_op == c_OP_JNZ);
    // JMP ignores the datapath condition entirely.
    assign w_taken = (r_br_op == c_OP_JMP) || BR_TAKEN;

    // Next-state, PC, counters and issue outputs; RUN=0 leaves everything held
    // and only drops the issue outputs to a bubble.
    always_comb begin
        w_state_nx    = r_state;
        w_pc_nx       = r_pc;
        w_gap_nx      = r_gap;
        w_wcnt_nx     = r_wcnt;
        w_br_op_nx    = r_br_op;
        w_br_tgt_nx   = r_br_tgt;
        w_ir_nx       = 10'b0;
        w_ir_valid_nx = 1'b0;
        w_stall_nx    = 1'b0;

        if (RUN) begin
            // Distance since the last writer keeps counting through bubbles.
            if (r_gap < c_GAP_MAX) begin
                w_gap_nx = r_gap + 1'b1;
            end

            case (r_state)
                S_FETCH: begin
                    if (w_is_br && (r_gap < c_GAP_MAX)) begin
                        w_stall_nx = 1'b1;
                    end else begin
                        w_ir_nx       = Q;
                        w_ir_valid_nx = 1'b1;
                        if (w_is_br) begin
                            w_br_op_nx  = w_op;
                            w_br_tgt_nx = Q[5:0];
                            w_wcnt_nx   = '0;
                            w_state_nx  = S_BR_WAIT;
                        end else begin
                            w_pc_nx = r_pc + 6'd1;
                            if (w_op != c_OP_NOP) begin
                                w_gap_nx = '0;
                            end
                        end
                    end
                end
                S_BR_WAIT: begin
                    if (r_wcnt == c_WAIT_LAST) begin
                        if (!w_taken) begin
                            w_pc_nx    = r_pc + 6'd1;
                            w_state_nx = S_FETCH;
                        end else if (r_br_tgt == r_pc) begin
                            w_state_nx = S_HALTED;
                        end else begin
                            w_pc_nx    = r_br_tgt;
                            w_state_nx = S_FETCH;
                        end
                    end else begin
                        w_wcnt_nx = r_wcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nx = S_HALTED;
                end
            endcase
        end

        w_halt_nx = (w_state_nx == S_HALTED);
    end

    // State register and registered issue outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_FETCH;
            r_pc       <= 6'd0;
            r_gap      <= c_GAP_MAX;
            r_wcnt     <= '0;
            r_br_op    <= 4'b0;
            r_br_tgt   <= 6'd0;
            r_ir       <= 10'b0;
            r_ir_valid <= 1'b0;
            r_stall    <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_pc       <= w_pc_nx;
            r_gap      <= w_gap_nx;
            r_wcnt     <= w_wcnt_nx;
            r_br_op    <= w_br_op_nx;
            r_br_tgt   <= w_br_tgt_nx;
            r_ir       <= w_ir_nx;
            r_ir_valid <= w_ir_valid_nx;
            r_stall    <= w_stall_nx;
            r_halt     <= w_halt_nx;
        end
    end

    assign AD       = r_pc;
    assign IR       = r_ir;
    assign IR_VALID = r_ir_valid;
    assign STALL    = r_stall;
    assign HALT     = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_issue_ctrl
//  Purpose  : Self-checking bench for fetch_issue_ctrl. A program-level model
//             expands each fetched instruction into its expected cycle-by-
//             cycle issue trace, which is compared against the DUT.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_issue_ctrl;

    localparam int H = 3;
    localparam int L = 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RUN;
    logic       BR_TAKEN;
    logic [5:0] AD;
    logic [9:0] Q;
    logic [9:0] IR;
    logic       IR_VALID;
    logic       STALL;
    logic       HALT;

    logic [9:0] rom [64];
    int         n_chk  = 0;
    int         n_fail = 0;

    fetch_issue_ctrl #(.HAZ_GAP(H), .BR_LAT(L)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RUN      (RUN),
        .AD       (AD),
        .Q        (Q),
        .BR_TAKEN (BR_TAKEN),
        .IR       (IR),
        .IR_VALID (IR_VALID),
        .STALL    (STALL),
        .HALT     (HALT)
    );

    always #5 CLK = ~CLK;
    assign Q = rom[AD];

    // One expected RUN=1 cycle: AD during the cycle and outputs after the edge.
    typedef struct packed {
        logic [5:0] ad;
        logic [9:0] ir;
        logic       irv;
        logic       stall;
        logic       halt;
        logic       bt_en;
        logic       bt;
    } ent_t;

    ent_t       m_q[$];
    logic [5:0] m_pc;
    int         m_since;
    logic       m_halted;
    logic       m_last_halt;
    int         m_force = -1;

    task automatic push(input logic [5:0] ad, input logic [9:0] ir, input logic irv,
                        input logic st, input logic ha, input logic be, input logic bt);
        ent_t e;
        e.ad = ad; e.ir = ir; e.irv = irv; e.stall = st; e.halt = ha; e.bt_en = be; e.bt = bt;
        m_q.push_back(e);
    endtask

    // Expand the instruction at the model PC into its full issue trace.
    task automatic gen();
        logic [9:0] w;
        logic [3:0] op;
        logic       taken;
        logic       stop;
        if (m_halted) begin
            push(m_pc, 10'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            return;
        end
        w  = rom[m_pc];
        op = w[9:6];
        if (op != 4'hB && op != 4'hC) begin
            push(m_pc, w, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            m_since = (op == 4'h0) ? ((m_since + 1 > H) ? H : m_since + 1) : 0;
            m_pc    = 6'(m_pc + 1);
        end else begin
            for (int i = m_since; i < H; i++)
                push(m_pc, 10'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            push(m_pc, w, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            m_since = H;
            if (op == 4'hB)       taken = 1'b1;
            else if (m_force >= 0) taken = m_force[0];
            else                   taken = 1'($urandom % 2);
            stop = taken && (w[5:0] == m_pc);
            for (int i = 1; i <= L; i++)
                push(m_pc, 10'b0, 1'b0, 1'b0, (i == L) && stop, (i == L) && (op == 4'hC), taken);
            if (stop) m_halted = 1'b1;
            else      m_pc = taken ? w[5:0] : 6'(m_pc + 1);
        end
    endtask

    // Drive one cycle; return observed {AD, IR, IR_VALID, STALL, HALT} and the model's value.
    task automatic step(input logic run, output logic [18:0] obs, output logic [18:0] exp);
        ent_t       e;
        logic [5:0] ad_pre;
        if (m_q.size() == 0) gen();
        e = m_q[0];
        @(negedge CLK);
        RUN      = run;
        BR_TAKEN = (run && e.bt_en) ? e.bt : 1'($urandom % 2);
        #1 ad_pre = AD;
        @(posedge CLK);
        #1;
        obs = {ad_pre, IR, IR_VALID, STALL, HALT};
        if (run) begin
            void'(m_q.pop_front());
            exp         = {e.ad, e.ir, e.irv, e.stall, e.halt};
            m_last_halt = e.halt;
        end else begin
            exp = {e.ad, 10'b0, 1'b0, 1'b0, m_last_halt};
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST      = 1'b1;
        RUN      = 1'($urandom % 2);
        BR_TAKEN = 1'($urandom % 2);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_q.delete();
        m_pc        = 6'd0;
        m_since     = H;
        m_halted    = 1'b0;
        m_last_halt = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 10'b0;
    endtask

    task automatic test_reset();
        logic [18:0] o, x;
        clear_rom();
        rom[0] = 10'b0001_000001;
        rom[1] = {4'hB, 6'd1};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, o, x);
            n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL reset_pre cyc%0d: got %h want %h", i, o, x); end
        end
        do_reset();
        n_chk++;
        if ({AD, IR, IR_VALID, STALL, HALT} !== 19'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", {AD, IR, IR_VALID, STALL, HALT});
        end
    endtask

    task automatic test_hazard_stall();
        logic [18:0] o, x;
        int          stalls = 0;
        clear_rom();
        rom[0] = 10'b0001_000101;
        rom[1] = {4'hC, 6'd0};
        m_force = 1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, o, x);
            if (o[1]) stalls++;
            n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL hazard cyc%0d: got %h want %h", i, o, x); end
        end
        n_chk++;
        if (stalls != 3) begin n_fail++; $display("FAIL hazard_stalls: got %0d want 3", stalls); end
        n_chk++;
        if (AD !== 6'd0) begin n_fail++; $display("FAIL hazard_target: AD got %0d want 0", AD); end
        m_force = -1;
    endtask

    task automatic test_no_stall();
        logic [18:0] o, x;
        int          stalls = 0;
        clear_rom();
        rom[0] = 10'b0010_000011;
        rom[4] = {4'hC, 6'd6};
        m_force = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, o, x);
            if (o[1]) stalls++;
            n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL nostall cyc%0d: got %h want %h", i, o, x); end
        end
        n_chk++;
        if (stalls != 0) begin n_fail++; $display("FAIL nostall_stalls: got %0d want 0", stalls); end
        n_chk++;
        if (AD !== 6'd5) begin n_fail++; $display("FAIL nostall_fallthru: AD got %0d want 5", AD); end
        m_force = -1;
    endtask

    task automatic test_halt();
        logic [18:0] o, x;
        clear_rom();
        rom[0]  = {4'hB, 6'd26};
        rom[26] = {4'hB, 6'd26};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, o, x);
            n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL halt_seq cyc%0d: got %h want %h", i, o, x); end
        end
        n_chk++;
        if (HALT !== 1'b1 || AD !== 6'd26) begin
            n_fail++;
            $display("FAIL halt_entry: HALT=%b AD=%0d want HALT=1 AD=26", HALT, AD);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'(i % 2), o, x);
            n_chk++;
            if (o[2] !== 1'b0 || o[0] !== 1'b1 || AD !== 6'd26) begin
                n_fail++;
                $display("FAIL halt_hold cyc%0d: irv=%b halt=%b AD=%0d want 0/1/26", i, o[2], o[0], AD);
            end
        end
        do_reset();
        n_chk++;
        if (HALT !== 1'b0 || AD !== 6'd0) begin
            n_fail++;
            $display("FAIL halt_release: HALT=%b AD=%0d want 0/0", HALT, AD);
        end
    endtask

    task automatic test_wrap();
        logic [18:0] o, x;
        clear_rom();
        rom[0] = {4'hB, 6'd62};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, o, x);
            n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL wrap cyc%0d: got %h want %h", i, o, x); end
            if (i == 4) begin
                n_chk++;
                if (o[18:13] !== 6'd62) begin n_fail++; $display("FAIL wrap_62: AD got %0d want 62", o[18:13]); end
            end
        end
        n_chk++;
        if (AD !== 6'd0) begin n_fail++; $display("FAIL wrap_0: AD got %0d want 0", AD); end
    endtask

    task automatic test_reset_midwait();
        logic [18:0] o, x;
        clear_rom();
        rom[0] = 10'b0011_000111;
        rom[1] = {4'hB, 6'd40};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, o, x);
            n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL midwait cyc%0d: got %h want %h", i, o, x); end
        end
        do_reset();
        n_chk++;
        if (AD !== 6'd0 || IR_VALID !== 1'b0 || HALT !== 1'b0) begin
            n_fail++;
            $display("FAIL midwait_reset: AD=%0d irv=%b halt=%b want 0/0/0", AD, IR_VALID, HALT);
        end
        step(1'b1, o, x);
        n_chk++;
        if (o !== x) begin n_fail++; $display("FAIL midwait_refetch: got %h want %h", o, x); end
    endtask

    task automatic test_run_freeze();
        logic [18:0] o, x;
        logic [5:0]  held;
        clear_rom();
        rom[0] = 10'b0100_001001;
        rom[2] = {4'hC, 6'd0};
        m_force = 1;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, o, x);
            n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL freeze_pre cyc%0d: got %h want %h", i, o, x); end
        end
        held = AD;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, o, x);
            n_chk++;
            if (o !== x || AD !== held) begin
                n_fail++;
                $display("FAIL freeze_hold cyc%0d: got %h AD=%0d want %h AD=%0d", i, o, AD, x, held);
            end
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b1, o, x);
            n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL freeze_resume cyc%0d: got %h want %h", i, o, x); end
        end
        m_force = -1;
    endtask

    task automatic test_random();
        logic [18:0] o, x;
        logic [3:0]  op;
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 64; a++) begin
                case ($urandom % 8)
                    0, 1, 2, 3: begin
                        do op = 4'($urandom); while (op == 4'h0 || op == 4'hB || op == 4'hC);
                        rom[a] = {op, 6'($urandom)};
                    end
                    4, 5:    rom[a] = {4'h0, 6'($urandom)};
                    6:       rom[a] = {4'hB, 6'($urandom)};
                    default: rom[a] = {4'hC, 6'($urandom)};
                endcase
            end
            do_reset();
            for (int i = 0; i < 300; i++) begin
                if ($urandom % 64 == 0) do_reset();
                step(1'($urandom % 5 != 0), o, x);
                n_chk++;
                if (o !== x) begin n_fail++; $display("FAIL random r%0d cyc%0d: got %h want %h", r, i, o, x); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        clear_rom();
        RST      = 1'b1;
        RUN      = 1'b0;
        BR_TAKEN = 1'b0;
        repeat (2) @(posedge CLK);
        test_reset();
        test_hazard_stall();
        test_no_stall();
        test_halt();
        test_wrap();
        test_reset_midwait();
        test_run_freeze();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
